// File: rtl/cbm_mul_unit.sv
// Column-based shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional early termination when the multiplier runs out of set bits: CBM_EARLY_TERM_EN.
module cbm_mul_unit #(
    parameter int XLEN = 32,
    parameter int COLS = 1,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            opcode_valid_i,
    input  logic [1:0]      opcode_op_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic [RD_W-1:0] opcode_rd_idx_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            writeback_valid_o,
    output logic [XLEN-1:0] writeback_value_o,
    output logic [RD_W-1:0] writeback_rd_idx_o
);

    localparam int N  = XLEN / COLS;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   accumulator_q;
    logic [PW-1:0]   multiplicand_q;
    logic [XLEN-1:0] multiplier_q;
    logic [CW-1:0]   count_q;
    logic [1:0]      op_q;
    logic            negate_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] wb_value_q;
    logic [RD_W-1:0] wb_rd_q;

    logic [PW-1:0]   accumulator_d;
    logic [PW-1:0]   multiplicand_d;
    logic [XLEN-1:0] multiplier_d;
    logic [PW-1:0]   product;
    logic [XLEN-1:0] result;
    logic            last_step;
    logic            accept;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign ready_o            = (state_q != ST_RUN);
    assign busy_o             = (state_q == ST_RUN);
    assign accept             = opcode_valid_i & ready_o & ~flush_i;
    assign writeback_valid_o  = (state_q == ST_DONE) & ~flush_i;
    assign writeback_value_o  = wb_value_q;
    assign writeback_rd_idx_o = wb_rd_q;

    assign sign_a = opcode_ra_operand_i[XLEN-1] &
                    ((opcode_op_i == 2'b01) | (opcode_op_i == 2'b10));
    assign sign_b = opcode_rb_operand_i[XLEN-1] & (opcode_op_i == 2'b01);
    assign mag_a  = sign_a ? -opcode_ra_operand_i : opcode_ra_operand_i;
    assign mag_b  = sign_b ? -opcode_rb_operand_i : opcode_rb_operand_i;

    always_comb begin
        accumulator_d = accumulator_q;
        for (int k = 0; k < COLS; k++) begin
            if (multiplier_q[k]) begin
                accumulator_d = accumulator_d + (multiplicand_q << k);
            end
        end
    end

    assign multiplicand_d = multiplicand_q << COLS;
    assign multiplier_d   = multiplier_q >> COLS;
    assign product        = negate_q ? -accumulator_d : accumulator_d;
    assign result         = (op_q == 2'b00) ? product[XLEN-1:0]
                                            : product[PW-1:XLEN];

`ifdef CBM_EARLY_TERM_EN
    assign last_step = (count_q == CW'(N - 1)) | (multiplier_d == '0);
`else
    assign last_step = (count_q == CW'(N - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= ST_IDLE;
            accumulator_q  <= '0;
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            count_q        <= '0;
            op_q           <= '0;
            negate_q       <= 1'b0;
            rd_q           <= '0;
            wb_value_q     <= '0;
            wb_rd_q        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_q        <= ST_RUN;
                        op_q           <= opcode_op_i;
                        rd_q           <= opcode_rd_idx_i;
                        negate_q       <= sign_a ^ sign_b;
                        accumulator_q  <= '0;
                        multiplicand_q <= {{XLEN{1'b0}}, mag_a};
                        multiplier_q   <= mag_b;
                        count_q        <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        accumulator_q  <= accumulator_d;
                        multiplicand_q <= multiplicand_d;
                        multiplier_q   <= multiplier_d;
                        count_q        <= count_q + CW'(1);
                        if (last_step) begin
                            state_q    <= ST_DONE;
                            wb_value_q <= result;
                            wb_rd_q    <= rd_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbm_mul_unit.sv
// Randomised and directed checks of cbm_mul_unit against a 64-bit arithmetic model.
// Expected latency follows CBM_EARLY_TERM_EN when defined.
module tb_cbm_mul_unit;

    localparam int XLEN = 32;
    localparam int COLS = 1;
    localparam int RD_W = 5;
    localparam int N    = XLEN / COLS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid = 1'b0;
    logic [1:0]      op = '0;
    logic [XLEN-1:0] ra = '0;
    logic [XLEN-1:0] rb = '0;
    logic [RD_W-1:0] rd = '0;
    logic            flush = 1'b0;
    logic            ready_o;
    logic            busy_o;
    logic            wb_valid;
    logic [XLEN-1:0] wb_value;
    logic [RD_W-1:0] wb_rd;

    int total = 0;
    int bad   = 0;

    cbm_mul_unit #(.XLEN(XLEN), .COLS(COLS), .RD_W(RD_W)) dut (
        .clk_i              (clk),
        .rst_i              (rst_n),
        .opcode_valid_i     (valid),
        .opcode_op_i        (op),
        .opcode_ra_operand_i(ra),
        .opcode_rb_operand_i(rb),
        .opcode_rd_idx_i    (rd),
        .flush_i            (flush),
        .ready_o            (ready_o),
        .busy_o             (busy_o),
        .writeback_valid_o  (wb_valid),
        .writeback_value_o  (wb_value),
        .writeback_rd_idx_o (wb_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        be = (o == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ae * be;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef CBM_EARLY_TERM_EN
        logic [31:0] m;
        int msb, steps;
        m   = (o == 2'b01 && b[31]) ? -b : b;
        msb = -1;
        for (int i = 0; i < XLEN; i++) if (m[i]) msb = i;
        steps = (msb + 1 + COLS - 1) / COLS;
        if (steps < 1) steps = 1;
        return steps + 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic drive(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [RD_W-1:0] d);
        valid = 1'b1;
        op    = o;
        ra    = a;
        rb    = b;
        rd    = d;
    endtask

    // Issues one op and waits for its pulse; latency counted from the accept edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [RD_W-1:0] d,
                         input logic [31:0] expv, input string tag);
        int n, busy_n;
        bit seen;
        @(negedge clk);
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        drive(o, a, b, d);
        @(negedge clk);
        valid  = 1'b0;
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (n < 200) begin
            if (wb_valid) begin
                seen = 1'b1;
                break;
            end
            if (busy_o) busy_n++;
            @(negedge clk);
            n++;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_lat"}, n, exp_lat(o, b));
        chk({tag, "_busy"}, busy_n, exp_lat(o, b) - 1);
        chk({tag, "_val"}, wb_value, expv);
        chk({tag, "_rd"}, wb_rd, d);
        @(negedge clk);
        chk({tag, "_pulse"}, wb_valid, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"}, ready_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_val"}, wb_value, 0);
        chk({tag, "_rd"}, wb_rd, 0);
    endtask

    initial begin
        int n, t, hits, pulses;
        logic [1:0] ro;
        logic [31:0] a, b;
        logic [31:0] corners [6];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;
        corners[5] = 32'h00010000;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_reset_outs("rst_idle");
        end

        do_op(2'b00, 32'd12345, 32'd6789, 5'd12, 32'd83810205, "mul_basic");
        do_op(2'b01, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, "mulh_min");
        do_op(2'b10, 32'hFFFFFFFF, 32'd2, 5'd2, 32'hFFFFFFFF, "mulhsu");
        do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, "mulhu");
        do_op(2'b00, -32'sd7, 32'd3, 5'd4, 32'hFFFFFFEB, "mul_neg");
        do_op(2'b00, 32'd5, 32'd3, 5'd5, 32'd15, "early_5x3");
        do_op(2'b00, 32'd99, 32'd0, 5'd6, 32'd0, "early_zero");

        // Back-to-back: second op held from the first RUN cycle onward.
        @(negedge clk);
        drive(2'b00, 32'd1000, 32'd77, 5'd7);
        @(negedge clk);
        drive(2'b11, 32'hDEADBEEF, 32'h12345678, 5'd8);
        n = 1;
        hits = 0;
        while (!wb_valid && n < 200) begin
            if (ready_o) hits++;
            @(negedge clk);
            n++;
        end
        chk("b2b_hold_rdy", hits, 0);
        chk("b2b_lat1", n, exp_lat(2'b00, 32'd77));
        chk("b2b_val1", wb_value, 32'd77000);
        chk("b2b_rdy_done", ready_o, 1);
        @(negedge clk);
        valid = 1'b0;
        t = 1;
        while (!wb_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_gap", t, exp_lat(2'b11, 32'h12345678));
        chk("b2b_val2", wb_value, ref_mul(2'b11, 32'hDEADBEEF, 32'h12345678));
        chk("b2b_rd2", wb_rd, 8);

        // Flush at RUN cycle 10 with a competing request.
        @(negedge clk);
        @(negedge clk);
        drive(2'b00, 32'd3, 32'hFFFF0000, 5'd9);
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_busy_pre", busy_o, 1);
        drive(2'b00, 32'd4, 32'd4, 5'd10);
        flush = 1'b1;
        #1;
        chk("flush_wbv", wb_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        chk("flush_busy", busy_o, 0);
        chk("flush_rdy", ready_o, 1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wb_valid) pulses++;
        end
        chk("flush_no_pulse", pulses, 0);

        // Flush landing in the DONE cycle suppresses the pulse.
        drive(2'b00, 32'd6, 32'd7, 5'd11);
        @(negedge clk);
        valid = 1'b0;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        flush = 1'b1;
        #1;
        chk("flush_done_wbv", wb_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_rdy", ready_o, 1);
        chk("flush_done_busy", busy_o, 0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            do_op(ro, a, b, 5'($urandom_range(0, 31)), ref_mul(ro, a, b),
                  $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a RUN.
        @(negedge clk);
        drive(2'b01, 32'h12345678, 32'h9ABCDEF0, 5'd13);
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cbm_mul_unit.md
# cbm_mul_unit

- Parametrised, multi-cycle column-based multiplier (CBM) execution unit for the biriscv core.
- Accepts one RV32M-style multiply from issue, computes the full 2·XLEN product by shift-add over COLS columns per cycle, and returns one registered writeback pulse.
- Successor to the fixed 32-bit, one-column, MUL-only CBM unit: adds configurable width and radix, the MULH/MULHSU/MULHU result modes, back-to-back acceptance and flush.
- Sits beside the ALU/LSU writeback ports; issue stalls dependent instructions while `busy_o` is high.

## Interface
- `XLEN`, 32: operand/result width, ≥8, power of two.
- `COLS`, 1: multiplier columns retired per cycle; power of two, divides XLEN.
- `RD_W`, 5: destination register index width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `opcode_valid_i` in 1: issue request.
- `opcode_op_i` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `opcode_ra_operand_i` in XLEN: multiplicand (rs1).
- `opcode_rb_operand_i` in XLEN: multiplier (rs2).
- `opcode_rd_idx_i` in RD_W: destination index.
- `flush_i` in 1: abort any in-flight operation.
- `ready_o` out 1: request accepted this cycle if `opcode_valid_i`.
- `busy_o` out 1: operation in RUN.
- `writeback_valid_o` out 1: one-cycle result pulse.
- `writeback_value_o` out XLEN: result.
- `writeback_rd_idx_o` out RD_W: destination of result.

## Operation
- States: IDLE, RUN, DONE (2-bit `state_q`).
- Accept = `opcode_valid_i & ready_o & !flush_i`. `ready_o` = state is IDLE or DONE (combinational from `state_q`).
- On accept:
  - latch rd_idx and op;
  - compute sign_a (ra[XLEN-1] when op is MULH/MULHSU) and sign_b (rb[XLEN-1] when op is MULH);
  - load `multiplicand_q` = |ra| zero-extended to 2·XLEN and `multiplier_q` = |rb|, with magnitudes taken only when the corresponding sign flag applies;
  - store `negate_q` = sign_a ^ sign_b and clear `accumulator_q`;
  - go to RUN.
- Magnitude of −2^(XLEN−1) is 2^(XLEN−1), representable unsigned; no special case.
- RUN step, for k = 0..COLS−1:
  - add `multiplicand_q << k` to the accumulator where `multiplier_q[k]` is set;
  - then `multiplicand_q <<= COLS` and `multiplier_q >>= COLS`.
- A step counter runs to XLEN/COLS. Leave RUN after the final step → DONE.
- DONE, one cycle:
  - `writeback_valid_o` = 1;
  - `writeback_value_o` = product[XLEN−1:0] for MUL, else product[2·XLEN−1:XLEN];
  - product = `negate_q` ? two's-complement of accumulator (2·XLEN) : accumulator.
  - Next state: RUN if a new accept occurs, else IDLE.
- `writeback_value_o` and `writeback_rd_idx_o` are registered and hold their last value outside DONE. The writeback pulse cannot be back-pressured.
- Accumulation is modulo 2^(2·XLEN); no overflow flag.
- Request while busy (RUN) is not accepted; it is the caller's job to hold it.
- `flush_i`:
  - in any state, forces IDLE next cycle and suppresses the writeback pulse of a DONE in the same cycle;
  - flush wins over a simultaneous valid.
- Reset mid-operation: immediate IDLE, all state cleared.

## Timing
- Reset values:
  - `ready_o`=1, `busy_o`=0, `writeback_valid_o`=0, `writeback_value_o`=0, `writeback_rd_idx_o`=0;
  - state IDLE, accumulator, multiplicand, multiplier and counter all 0.
- Accept sampled at the end of cycle T.
- RUN spans cycles T+1..T+N, with N = XLEN/COLS (`busy_o`=1 there).
- `writeback_valid_o` is high in cycle T+N+1.
- Latency is N+1, e.g. 33 cycles for XLEN=32, COLS=1, and 9 cycles for COLS=4.
- Back-to-back: an accept in the DONE cycle starts the next RUN at the following cycle; throughput is one op per N+1 cycles.

## Configuration
- `CBM_EARLY_TERM_EN` defined:
  - RUN also exits to DONE after any step in which the post-shift `multiplier_q` is zero;
  - minimum one RUN cycle (multiplier zero at accept still takes one step);
  - latency becomes max(1, ceil((msb(|rb|)+1)/COLS)) + 1.
- Undefined: fixed N RUN cycles always. Results are identical either way.

## Test plan
- Reset release, no requests → all outputs at reset values for 10 cycles; `ready_o`=1.
- XLEN=32, COLS=1, MUL ra=12345 rb=6789, rd=12:
  - `busy_o` high 32 cycles;
  - at T+33 a single pulse with value=83810205, rd=12.
- MULH ra=0x80000000 rb=0x80000000 → 0x40000000; MULHSU ra=0xFFFFFFFF rb=2 → 0xFFFFFFFF; MULHU ra=0xFFFFFFFF rb=0xFFFFFFFF → 0xFFFFFFFE; MUL ra=−7 rb=3 → 0xFFFFFFEB.
- Back-to-back: second op presented during DONE is accepted (`ready_o`=1) → second pulse exactly 33 cycles after the first; a request held during RUN is not accepted until DONE.
- `flush_i` asserted at RUN cycle 10 together with a new `opcode_valid_i` → no writeback pulse, IDLE next cycle, `ready_o`=1; reset asserted mid-RUN → outputs return to reset values asynchronously.
- Early termination:
  - with `CBM_EARLY_TERM_EN`, MUL ra=5 rb=3 at COLS=1 → writeback at T+3 value 15;
  - rb=0 → writeback at T+2 value 0;
  - without the macro, both at T+33.
